// File: rtl/mc_ctl_pkg.sv
// mc_ctl_pkg: shared types and encodings for the multi-cycle MIPS controller.
// Contents: FSM state enum, instruction classes, opcode/funct values,
// 5-bit ALU operation codes, pc_src / RegDst / MemToReg / excp_cause encodings.
package mc_ctl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_EXCP
   } state_e;

   typedef enum logic [3:0] {
      CLS_R,
      CLS_I,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_BNE,
      CLS_J,
      CLS_JAL,
      CLS_JR
   } cls_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam int ALU_CODE_W = 5;
   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b11000;
   localparam logic [4:0] ALU_OR  = 5'b11110;
   localparam logic [4:0] ALU_XOR = 5'b10110;
   localparam logic [4:0] ALU_NOR = 5'b10001;
   localparam logic [4:0] ALU_SLT = 5'b00111;
   localparam logic [4:0] ALU_SLL = 5'b01000;
   localparam logic [4:0] ALU_SRL = 5'b01001;
   localparam logic [4:0] ALU_SRA = 5'b01011;
   localparam logic [4:0] ALU_CMP = 5'b00101;

   localparam logic [2:0] PC_SEQ    = 3'b000;
   localparam logic [2:0] PC_BRANCH = 3'b001;
   localparam logic [2:0] PC_JUMP   = 3'b010;
   localparam logic [2:0] PC_RS     = 3'b011;
   localparam logic [2:0] PC_EXCP   = 3'b100;

   localparam logic [1:0] RD_RD = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctl_if.sv
// mc_ctl_if: shared memory port between the controller and memory.
// mem_req/mem_we/mem_iord driven by the controller (master),
// mem_ready driven by memory (slave) to complete the current request.
interface mc_ctl_if;
   logic mem_req;
   logic mem_we;
   logic mem_iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_iord, output mem_ready);
endinterface

// File: rtl/mc_ctl_decode.sv
// mc_ctl_decode: combinational instruction decode.
// Inputs : opCode, funct (from IR)
// Outputs: legal (instruction supported), cls (instruction class),
//          alu_code (5-bit ALU op for EXEC), alu_src (immediate/shamt operand)
module mc_ctl_decode
   import mc_ctl_pkg::*;
(
   input  logic [5:0]            opCode,
   input  logic [5:0]            funct,
   output logic                  legal,
   output cls_e                  cls,
   output logic [ALU_CODE_W-1:0] alu_code,
   output logic                  alu_src
);

   always_comb begin
      legal    = 1'b1;
      cls      = CLS_R;
      alu_code = ALU_ADD;
      alu_src  = 1'b0;
      case (opCode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: alu_code = ALU_ADD;
               FN_SUB: alu_code = ALU_SUB;
               FN_AND: alu_code = ALU_AND;
               FN_OR:  alu_code = ALU_OR;
               FN_XOR: alu_code = ALU_XOR;
               FN_NOR: alu_code = ALU_NOR;
               FN_SLT: alu_code = ALU_SLT;
               FN_SLL: begin alu_code = ALU_SLL; alu_src = 1'b1; end
               FN_SRL: begin alu_code = ALU_SRL; alu_src = 1'b1; end
               FN_SRA: begin alu_code = ALU_SRA; alu_src = 1'b1; end
               FN_JR:  cls = CLS_JR;
               default: legal = 1'b0;
            endcase
         end
         OP_ADDI: begin cls = CLS_I;   alu_src = 1'b1; end
         OP_ANDI: begin cls = CLS_I;   alu_src = 1'b1; alu_code = ALU_AND; end
         OP_ORI:  begin cls = CLS_I;   alu_src = 1'b1; alu_code = ALU_OR;  end
         OP_XORI: begin cls = CLS_I;   alu_src = 1'b1; alu_code = ALU_XOR; end
         OP_LW:   begin cls = CLS_LW;  alu_src = 1'b1; end
         OP_SW:   begin cls = CLS_SW;  alu_src = 1'b1; end
         OP_BEQ:  begin cls = CLS_BEQ; alu_code = ALU_CMP; end
         OP_BNE:  begin cls = CLS_BNE; alu_code = ALU_CMP; end
         OP_J:    cls = CLS_J;
         OP_JAL:  cls = CLS_JAL;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctl.sv
// mc_ctl: multi-cycle MIPS control FSM with memory timeout and exceptions.
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   opCode, funct, zero  - IR fields and ALU zero flag
//   mem (mc_ctl_if)      - memory req/we/iord out, ready in
//   ir_write, mdr_write, pc_write, pc_src      - PC/IR/MDR enables
//   RegDst, ALUSrc, RegWrite, MemToReg, ALUOp  - datapath controls
//   excp, excp_cause, epc_write, retire        - exception / retire status
//   perf_cycles, perf_instrs                   - performance counters
// Optional feature macro: MCCTL_PERF_EN enables the performance counters;
// otherwise both counter ports are tied to zero.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_FETCH  | instruction read; IR and PC+4 loaded on mem_ready
// S_DECODE | legality check; jumps complete here
// S_EXEC   | ALU operation; branches complete here
// S_MEM    | data access for lw/sw
// S_WB     | register-file write-back
// S_EXCP   | one-cycle exception vectoring, EPC capture
module mc_ctl
   import mc_ctl_pkg::*;
#(
   parameter int ALUOP_W        = 5,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int PERF_W         = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opCode,
   input  logic [5:0]         funct,
   input  logic               zero,
   mc_ctl_if.master           mem,
   output logic               ir_write,
   output logic               mdr_write,
   output logic               pc_write,
   output logic [2:0]         pc_src,
   output logic [1:0]         RegDst,
   output logic               ALUSrc,
   output logic               RegWrite,
   output logic [1:0]         MemToReg,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               excp,
   output logic [1:0]         excp_cause,
   output logic               epc_write,
   output logic               retire,
   output logic [PERF_W-1:0]  perf_cycles,
   output logic [PERF_W-1:0]  perf_instrs
);

   // wait_cnt holds the number of unanswered cycles so far; the request
   // times out on the cycle that would make it TIMEOUT_CYCLES.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e                  state, state_next;
   logic [CNT_W-1:0]        wait_cnt;
   logic [1:0]              cause_q, cause_next;
   logic                    dec_legal, dec_alu_src;
   cls_e                    dec_cls;
   logic [ALU_CODE_W-1:0]   dec_alu_code, aluop_c;
   logic                    req_c, we_c, iord_c, timeout_hit, mem_wait;

   mc_ctl_decode u_decode (
      .opCode   (opCode),
      .funct    (funct),
      .legal    (dec_legal),
      .cls      (dec_cls),
      .alu_code (dec_alu_code),
      .alu_src  (dec_alu_src)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
   assign mem_wait    = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state   <= state_next;
         cause_q <= cause_next;
         if (state_next != state)
            wait_cnt <= '0;
         else if (mem_wait)
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      cause_next = cause_q;
      req_c      = 1'b0;
      we_c       = 1'b0;
      iord_c     = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      RegDst     = RD_RD;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = M2R_ALU;
      aluop_c    = ALU_ADD;
      excp       = 1'b0;
      epc_write  = 1'b0;
      retire     = 1'b0;
      // Outputs stay quiet through the reset cycle regardless of state.
      if (reset) begin
         state_next = S_FETCH;
      end else begin
         case (state)
            S_FETCH: begin
               req_c = 1'b1;
               if (mem.mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_DECODE;
               end else if (timeout_hit) begin
                  cause_next = CAUSE_TIMEOUT;
                  state_next = S_EXCP;
               end
            end
            S_DECODE: begin
               if (!dec_legal) begin
                  cause_next = CAUSE_ILLEGAL;
                  state_next = S_EXCP;
               end else begin
                  case (dec_cls)
                     CLS_J, CLS_JR: begin
                        pc_write   = 1'b1;
                        pc_src     = (dec_cls == CLS_JR) ? PC_RS : PC_JUMP;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                     end
                     CLS_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JUMP;
                        RegWrite   = 1'b1;
                        RegDst     = RD_RA;
                        MemToReg   = M2R_PC;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                     end
                     default: state_next = S_EXEC;
                  endcase
               end
            end
            S_EXEC: begin
               ALUSrc  = dec_alu_src;
               aluop_c = dec_alu_code;
               case (dec_cls)
                  CLS_BEQ, CLS_BNE: begin
                     pc_write   = (dec_cls == CLS_BEQ) ? zero : !zero;
                     pc_src     = PC_BRANCH;
                     retire     = 1'b1;
                     state_next = S_FETCH;
                  end
                  CLS_LW, CLS_SW: state_next = S_MEM;
                  default:        state_next = S_WB;
               endcase
            end
            S_MEM: begin
               req_c  = 1'b1;
               iord_c = 1'b1;
               we_c   = (dec_cls == CLS_SW);
               if (mem.mem_ready) begin
                  if (dec_cls == CLS_LW) begin
                     mdr_write  = 1'b1;
                     state_next = S_WB;
                  end else begin
                     retire     = 1'b1;
                     state_next = S_FETCH;
                  end
               end else if (timeout_hit) begin
                  cause_next = CAUSE_TIMEOUT;
                  state_next = S_EXCP;
               end
            end
            S_WB: begin
               RegWrite   = 1'b1;
               RegDst     = ((dec_cls == CLS_I) || (dec_cls == CLS_LW)) ? RD_RT : RD_RD;
               MemToReg   = (dec_cls == CLS_LW) ? M2R_MDR : M2R_ALU;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            S_EXCP: begin
               excp       = 1'b1;
               epc_write  = 1'b1;
               pc_write   = 1'b1;
               pc_src     = PC_EXCP;
               state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

   assign mem.mem_req  = req_c;
   assign mem.mem_we   = we_c;
   assign mem.mem_iord = iord_c;
   assign ALUOp        = ALUOP_W'(aluop_c);
   assign excp_cause   = reset ? CAUSE_NONE : cause_q;

`ifdef MCCTL_PERF_EN
   logic [PERF_W-1:0] cyc_q, ins_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_q + PERF_W'(1);
         if (retire)
            ins_q <= ins_q + PERF_W'(1);
      end
   end

   assign perf_cycles = reset ? '0 : cyc_q;
   assign perf_instrs = reset ? '0 : ins_q;
`else
   assign perf_cycles = '0;
   assign perf_instrs = '0;
`endif

endmodule

// File: tb/tb_mc_ctl.sv
// tb_mc_ctl: directed self-checking bench for mc_ctl (TIMEOUT_CYCLES=16).
module tb_mc_ctl;

   typedef struct packed {
      logic       req, we, iord, irw, mdrw, pcw;
      logic [2:0] pcsrc;
      logic [1:0] regdst;
      logic       alusrc, regw;
      logic [1:0] m2r;
      logic [4:0] aluop;
      logic       excp;
      logic [1:0] cause;
      logic       epcw, retire;
   } ctl_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opCode = '0;
   logic [5:0]  funct = '0;
   logic        zero = 1'b0;
   logic        ir_write, mdr_write, pc_write, ALUSrc, RegWrite;
   logic        excp, epc_write, retire;
   logic [2:0]  pc_src;
   logic [1:0]  RegDst, MemToReg, excp_cause;
   logic [4:0]  ALUOp;
   logic [31:0] perf_cycles, perf_instrs;

   int          n_chk = 0;
   int          n_err = 0;
   logic [1:0]  cause = 2'b00;

   mc_ctl_if mbus ();

   mc_ctl #(.ALUOP_W(5), .TIMEOUT_CYCLES(16), .PERF_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .opCode      (opCode),
      .funct       (funct),
      .zero        (zero),
      .mem         (mbus),
      .ir_write    (ir_write),
      .mdr_write   (mdr_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .RegDst      (RegDst),
      .ALUSrc      (ALUSrc),
      .RegWrite    (RegWrite),
      .MemToReg    (MemToReg),
      .ALUOp       (ALUOp),
      .excp        (excp),
      .excp_cause  (excp_cause),
      .epc_write   (epc_write),
      .retire      (retire),
      .perf_cycles (perf_cycles),
      .perf_instrs (perf_instrs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic ctl_t sample();
      ctl_t s;
      s.req    = mbus.mem_req;
      s.we     = mbus.mem_we;
      s.iord   = mbus.mem_iord;
      s.irw    = ir_write;
      s.mdrw   = mdr_write;
      s.pcw    = pc_write;
      s.pcsrc  = pc_src;
      s.regdst = RegDst;
      s.alusrc = ALUSrc;
      s.regw   = RegWrite;
      s.m2r    = MemToReg;
      s.aluop  = ALUOp;
      s.excp   = excp;
      s.cause  = excp_cause;
      s.epcw   = epc_write;
      s.retire = retire;
      return s;
   endfunction

   function automatic ctl_t nb();
      ctl_t t = '0;
      t.cause = cause;
      return t;
   endfunction

   function automatic ctl_t ef();
      ctl_t t = nb();
      t.req = 1'b1; t.irw = 1'b1; t.pcw = 1'b1;
      return t;
   endfunction

   // Check the current cycle at the falling edge, then advance past the next rising edge.
   task automatic cyc(input string tag, input ctl_t e);
      @(negedge clk);
      chk(tag, 32'(sample()), 32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic alu_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] aop, input logic src, input logic [1:0] dst);
      ctl_t e;
      opCode = op; funct = fn; mbus.mem_ready = 1'b1;
      cyc({tag, " F"}, ef());
      cyc({tag, " D"}, nb());
      e = nb(); e.alusrc = src; e.aluop = aop;
      cyc({tag, " E"}, e);
      e = nb(); e.regw = 1'b1; e.regdst = dst; e.retire = 1'b1;
      cyc({tag, " W"}, e);
   endtask

   task automatic br(input string tag, input logic [5:0] op, input logic z, input logic pcw);
      ctl_t e;
      opCode = op; funct = 6'h15; zero = z; mbus.mem_ready = 1'b1;
      cyc({tag, " F"}, ef());
      cyc({tag, " D"}, nb());
      e = nb(); e.pcw = pcw; e.pcsrc = 3'b001; e.aluop = 5'b00101; e.retire = 1'b1;
      cyc({tag, " E"}, e);
   endtask

   task automatic jmp(input string tag, input logic [5:0] op, input logic [5:0] fn, input ctl_t ed);
      opCode = op; funct = fn; mbus.mem_ready = 1'b1;
      cyc({tag, " F"}, ef());
      cyc({tag, " D"}, ed);
   endtask

   initial begin
      ctl_t e;
      mbus.mem_ready = 1'b1;

      // reset cycle: every output low
      cyc("reset", nb());
      reset = 1'b0;

      alu_instr("add",  6'h00, 6'h20, 5'b00000, 1'b0, 2'b00);
      alu_instr("sub",  6'h00, 6'h22, 5'b00001, 1'b0, 2'b00);
      alu_instr("and",  6'h00, 6'h24, 5'b11000, 1'b0, 2'b00);
      alu_instr("nor",  6'h00, 6'h27, 5'b10001, 1'b0, 2'b00);
      alu_instr("slt",  6'h00, 6'h2a, 5'b00111, 1'b0, 2'b00);
      alu_instr("sll",  6'h00, 6'h00, 5'b01000, 1'b1, 2'b00);
      alu_instr("sra",  6'h00, 6'h03, 5'b01011, 1'b1, 2'b00);
      alu_instr("addi", 6'h08, 6'h2a, 5'b00000, 1'b1, 2'b01);
      alu_instr("ori",  6'h0d, 6'h3f, 5'b11110, 1'b1, 2'b01);
      alu_instr("xori", 6'h0e, 6'h11, 5'b10110, 1'b1, 2'b01);

      // lw with memory answering on the 4th MEM cycle
      opCode = 6'h23; funct = 6'h05; mbus.mem_ready = 1'b1;
      cyc("lw F", ef());
      cyc("lw D", nb());
      e = nb(); e.alusrc = 1'b1; cyc("lw E", e);
      mbus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = nb(); e.req = 1'b1; e.iord = 1'b1; cyc("lw M wait", e);
      end
      mbus.mem_ready = 1'b1;
      e = nb(); e.req = 1'b1; e.iord = 1'b1; e.mdrw = 1'b1; cyc("lw M done", e);
      e = nb(); e.regw = 1'b1; e.regdst = 2'b01; e.m2r = 2'b01; e.retire = 1'b1;
      cyc("lw W", e);

      // sw in four cycles
      opCode = 6'h2b;
      cyc("sw F", ef());
      cyc("sw D", nb());
      e = nb(); e.alusrc = 1'b1; cyc("sw E", e);
      e = nb(); e.req = 1'b1; e.we = 1'b1; e.iord = 1'b1; e.retire = 1'b1;
      cyc("sw M", e);

      br("beq z0", 6'h04, 1'b0, 1'b0);
      br("beq z1", 6'h04, 1'b1, 1'b1);
      br("bne z0", 6'h05, 1'b0, 1'b1);
      br("bne z1", 6'h05, 1'b1, 1'b0);
      zero = 1'b0;

      e = nb(); e.pcw = 1'b1; e.pcsrc = 3'b010; e.retire = 1'b1;
      jmp("j", 6'h02, 6'h00, e);
      e = nb(); e.pcw = 1'b1; e.pcsrc = 3'b011; e.retire = 1'b1;
      jmp("jr", 6'h00, 6'h08, e);
      e = nb(); e.pcw = 1'b1; e.pcsrc = 3'b010; e.regw = 1'b1; e.regdst = 2'b10;
      e.m2r = 2'b10; e.retire = 1'b1;
      jmp("jal", 6'h03, 6'h00, e);

      // illegal opcode
      jmp("ill op", 6'h3f, 6'h00, nb());
      cause = 2'b01;
      e = nb(); e.excp = 1'b1; e.epcw = 1'b1; e.pcw = 1'b1; e.pcsrc = 3'b100;
      cyc("ill op X", e);
      // illegal R-type funct; cause stays 01
      jmp("ill fn", 6'h00, 6'h01, nb());
      cyc("ill fn X", e);
      alu_instr("add2", 6'h00, 6'h20, 5'b00000, 1'b0, 2'b00);

      // fetch timeout after 16 unanswered cycles
      mbus.mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         e = nb(); e.req = 1'b1; cyc("to wait", e);
      end
      cause = 2'b10;
      e = nb(); e.excp = 1'b1; e.epcw = 1'b1; e.pcw = 1'b1; e.pcsrc = 3'b100;
      cyc("to X", e);

      // ready on the 16th wait cycle completes the fetch normally
      opCode = 6'h02; funct = 6'h00;
      for (int i = 0; i < 15; i++) begin
         e = nb(); e.req = 1'b1; cyc("edge wait", e);
      end
      mbus.mem_ready = 1'b1;
      cyc("edge F", ef());
      e = nb(); e.pcw = 1'b1; e.pcsrc = 3'b010; e.retire = 1'b1;
      cyc("edge D", e);

      // reset during sw MEM abandons the request
      opCode = 6'h2b;
      cyc("rsw F", ef());
      cyc("rsw D", nb());
      e = nb(); e.alusrc = 1'b1; cyc("rsw E", e);
      mbus.mem_ready = 1'b0;
      e = nb(); e.req = 1'b1; e.we = 1'b1; e.iord = 1'b1; cyc("rsw M", e);
      reset = 1'b1; cause = 2'b00;
      cyc("rsw reset", nb());
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = nb(); e.req = 1'b1; cyc("rsw refetch", e);
      end
      alu_instr("add3", 6'h00, 6'h20, 5'b00000, 1'b0, 2'b00);

      // performance counters over 10 R-type instructions after reset
      reset = 1'b1;
      cyc("perf reset", nb());
      reset = 1'b0;
      for (int i = 0; i < 10; i++)
         alu_instr("perf add", 6'h00, 6'h20, 5'b00000, 1'b0, 2'b00);
`ifdef MCCTL_PERF_EN
      chk("perf_instrs", perf_instrs, 32'd10);
      chk("perf_cycles", perf_cycles, 32'd40);
`else
      chk("perf_instrs", perf_instrs, 32'd0);
      chk("perf_cycles", perf_cycles, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
